// File: rtl/servo_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | servo_pkg : shared constants and pulse-width helper for servo PWM     |
// | Revision  : 1.0                                                       |
// +-----------------------------------------------------------------------+
package servo_pkg;

    localparam int IDX_W          = 3;
    localparam int DEF_PERIOD_CYC = 1_000_000;
    localparam int DEF_MIN_PULSE  = 25_000;
    localparam int DEF_STEP_PULSE = 25_000;
    localparam int DEF_SLEW       = 5_000;
    localparam int DEF_DEB_CYC    = 2_500_000;
    localparam int DEF_SWEEP_CYC  = 50_000_000;

    // High time in clock cycles for a given position index.
    function automatic int pulse_of(input int min_pulse, input int step_pulse,
                                    input logic [IDX_W-1:0] idx);
        return min_pulse + step_pulse * int'(idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/servo_debounce.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | servo_debounce : sampled two-match debouncer with press strobe        |
// | Revision       : 1.0                                                  |
// +-----------------------------------------------------------------------+
module servo_debounce #(
    parameter int WIDTH   = 8,
    parameter int PRESS_W = 5,
    parameter int DEB_CYC = 2_500_000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] acc,
    output logic             press
);

    localparam int               CNT_W    = $clog2(DEB_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] last_smp;
    logic [CNT_W-1:0] cnt;
    logic             smp_tick;

    assign smp_tick = (cnt == CNT_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1    <= '0;
            sync2    <= '0;
            last_smp <= '0;
            acc      <= '0;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            press <= 1'b0;
            cnt   <= smp_tick ? '0 : cnt + 1'b1;
            if (smp_tick) begin
                last_smp <= sync2;
                // Two equal consecutive samples that differ from the held value.
                if ((sync2 == last_smp) && (sync2 != acc)) begin
                    acc   <= sync2;
                    press <= |sync2[PRESS_W-1:0];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/multi_servo_pwm.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | multi_servo_pwm : N-channel servo PWM with keypad, sweep and slew     |
// | Revision        : 1.0                                                 |
// +-----------------------------------------------------------------------+
module multi_servo_pwm
    import servo_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int N_POS      = 5,
    parameter int PERIOD_CYC = DEF_PERIOD_CYC,
    parameter int MIN_PULSE  = DEF_MIN_PULSE,
    parameter int STEP_PULSE = DEF_STEP_PULSE,
    parameter int SLEW       = DEF_SLEW,
    parameter int DEB_CYC    = DEF_DEB_CYC,
    parameter int SWEEP_CYC  = DEF_SWEEP_CYC
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [N_CH-1:0]       modo,
    input  logic [2:0]            ch_sel,
    input  logic [N_POS-1:0]      pos_sel,
    output logic [N_CH-1:0]       PWM,
    output logic [N_CH*IDX_W-1:0] posi,
    output logic                  frame_start
);

    localparam int               PW_W       = $clog2(PERIOD_CYC + 1);
    localparam int               SW_W       = $clog2(SWEEP_CYC + 1);
    localparam int               KEY_W      = IDX_W + N_POS;
    localparam logic [PW_W-1:0]  FRAME_LAST = PW_W'(PERIOD_CYC - 1);
    localparam logic [PW_W-1:0]  SLEW_V     = PW_W'(SLEW);
    localparam logic [PW_W-1:0]  MIN_V      = PW_W'(MIN_PULSE);
    localparam logic [SW_W-1:0]  SWEEP_LAST = SW_W'(SWEEP_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_POS - 1);

    if ((MIN_PULSE + (N_POS - 1) * STEP_PULSE >= PERIOD_CYC) ||
        (N_CH < 1) || (N_CH > 8) || (N_POS < 2) || (N_POS > 8)) begin : g_param_check
        $error("multi_servo_pwm: parameter set out of range");
    end

    logic [PW_W-1:0]  frame_cnt;
    logic             frame_last;
    logic [SW_W-1:0]  sweep_cnt;
    logic             sweep_tick;
    logic [KEY_W-1:0] key_acc;
    logic             key_press;
    logic [IDX_W-1:0] key_ch;
    logic [N_POS-1:0] key_pos;
    logic [IDX_W-1:0] key_idx;
    logic             key_onehot;
    logic [N_CH-1:0]  pwm_d;

    assign frame_last = (frame_cnt == FRAME_LAST);
    assign sweep_tick = (sweep_cnt == SWEEP_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            frame_cnt   <= '0;
            sweep_cnt   <= '0;
            frame_start <= 1'b0;
            PWM         <= '0;
        end else begin
            frame_cnt   <= frame_last ? '0 : frame_cnt + 1'b1;
            sweep_cnt   <= sweep_tick ? '0 : sweep_cnt + 1'b1;
            frame_start <= frame_last;
            PWM         <= pwm_d;
        end
    end

    servo_debounce #(
        .WIDTH   (KEY_W),
        .PRESS_W (N_POS),
        .DEB_CYC (DEB_CYC)
    ) u_debounce (
        .CLK   (CLK),
        .RST_N (RST_N),
        .din   ({ch_sel, pos_sel}),
        .acc   (key_acc),
        .press (key_press)
    );

    assign key_ch     = key_acc[KEY_W-1:N_POS];
    assign key_pos    = key_acc[N_POS-1:0];
    assign key_onehot = (key_pos != '0) && ((key_pos & (key_pos - 1'b1)) == '0);

    always_comb begin
        key_idx = '0;
        for (int b = 0; b < N_POS; b++) begin
            if (key_pos[b]) key_idx = IDX_W'(b);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [IDX_W-1:0] idx;
        logic [PW_W-1:0]  tgt;
        logic [PW_W-1:0]  cur;
        logic [PW_W-1:0]  cur_next;
        logic             key_hit;

        assign key_hit = key_press && key_onehot && (key_ch == IDX_W'(i));

        // Mode selects the single source of index updates for this channel.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                idx <= '0;
            end else if (modo[i]) begin
                if (sweep_tick) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else if (key_hit) begin
                idx <= key_idx;
            end
        end

        assign tgt = PW_W'(pulse_of(MIN_PULSE, STEP_PULSE, idx));

        always_comb begin
            cur_next = tgt;
            if (SLEW != 0) begin
                if ((tgt > cur) && ((tgt - cur) > SLEW_V))      cur_next = cur + SLEW_V;
                else if ((cur > tgt) && ((cur - tgt) > SLEW_V)) cur_next = cur - SLEW_V;
            end
        end

        // Width changes only on the last frame cycle so every pulse is whole.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N)          cur <= MIN_V;
            else if (frame_last) cur <= cur_next;
        end

        assign pwm_d[i]                 = (frame_cnt < cur);
        assign posi[IDX_W*i +: IDX_W]   = idx;
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_servo_pwm.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | tb_multi_servo_pwm : scoreboard bench, SLEW=0 and SLEW=50 instances   |
// | Revision           : 1.0                                              |
// +-----------------------------------------------------------------------+
module tb_multi_servo_pwm;

    localparam int N_CH   = 4;
    localparam int N_POS  = 5;
    localparam int PERIOD = 1000;
    localparam int MINP   = 100;
    localparam int STEPP  = 100;
    localparam int DEB    = 20;
    localparam int SWEEP  = 3000;
    localparam int SLEW_B = 50;
    localparam int FR_PER_TICK = SWEEP / PERIOD;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [3:0]  modo = '0;
    logic [2:0]  ch_sel = '0;
    logic [4:0]  pos_sel = '0;
    logic [3:0]  pwm_a, pwm_b;
    logic [11:0] posi_a, posi_b;
    logic        fs_a, fs_b;

    always #5 CLK = ~CLK;

    multi_servo_pwm #(.N_CH(N_CH), .N_POS(N_POS), .PERIOD_CYC(PERIOD), .MIN_PULSE(MINP),
        .STEP_PULSE(STEPP), .SLEW(0), .DEB_CYC(DEB), .SWEEP_CYC(SWEEP)) dut_a (
        .CLK(CLK), .RST_N(RST_N), .modo(modo), .ch_sel(ch_sel), .pos_sel(pos_sel),
        .PWM(pwm_a), .posi(posi_a), .frame_start(fs_a));

    multi_servo_pwm #(.N_CH(N_CH), .N_POS(N_POS), .PERIOD_CYC(PERIOD), .MIN_PULSE(MINP),
        .STEP_PULSE(STEPP), .SLEW(SLEW_B), .DEB_CYC(DEB), .SWEEP_CYC(SWEEP)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .modo(modo), .ch_sel(ch_sel), .pos_sel(pos_sel),
        .PWM(pwm_b), .posi(posi_b), .frame_start(fs_b));

    typedef struct packed {
        logic [3:0][15:0] wa;
        logic [3:0][15:0] wb;
        logic [11:0]      posi;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    int         idx_m [N_CH];
    int         cur_a [N_CH];
    int         cur_b [N_CH];
    logic [3:0] modo_m;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int slew_to(input int cur, input int tgt, input int s);
        if (s == 0 || ((tgt - cur) <= s && (cur - tgt) <= s)) return tgt;
        return (tgt > cur) ? cur + s : cur - s;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            idx_m[c] = 0;
            cur_a[c] = MINP;
            cur_b[c] = MINP;
        end
        modo_m = '0;
        exp_q.delete();
    endtask

    // Frame f is finishing: record its widths, then apply boundary and sweep effects.
    task automatic end_of_frame(input int f);
        exp_t e;
        for (int c = 0; c < N_CH; c++) begin
            e.wa[c]  = 16'(cur_a[c]);
            e.wb[c]  = 16'(cur_b[c]);
            cur_a[c] = slew_to(cur_a[c], MINP + idx_m[c] * STEPP, 0);
            cur_b[c] = slew_to(cur_b[c], MINP + idx_m[c] * STEPP, SLEW_B);
        end
        if ((f % FR_PER_TICK) == FR_PER_TICK - 1) begin
            for (int c = 0; c < N_CH; c++)
                if (modo_m[c]) idx_m[c] = (idx_m[c] + 1) % N_POS;
        end
        for (int c = 0; c < N_CH; c++) e.posi[3*c +: 3] = 3'(idx_m[c]);
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // kind: 0 idle, 1 held press, 2 short glitch, 3 mode change
    task automatic run_frame(input int f, input int kind, input int ch,
                             input logic [4:0] pos, input logic [3:0] new_modo);
        int used;
        wait_cyc(5);
        used = 5;
        case (kind)
            1: begin
                ch_sel  = 3'(ch);
                pos_sel = pos;
                wait_cyc(60);
                pos_sel = '0;
                used += 60;
                if ($countones(pos) == 1 && ch < N_CH && !modo_m[ch])
                    idx_m[ch] = $clog2(pos);
            end
            2: begin
                ch_sel  = 3'(ch);
                pos_sel = pos;
                wait_cyc(5);
                pos_sel = '0;
                used += 5;
            end
            3: begin
                modo   = new_modo;
                modo_m = new_modo;
            end
            default: ;
        endcase
        wait_cyc(PERIOD - 1 - used);
        end_of_frame(f);
        wait_cyc(1);
    endtask

    task automatic release_reset();
        @(posedge CLK);
        #1 RST_N = 1'b1;
        @(negedge CLK);
    endtask

    // Monitor: one scoreboard pop per DUT frame_start.
    initial begin : monitor
        int   hi_a [N_CH];
        int   hi_b [N_CH];
        int   cyc;
        exp_t e;
        cyc = 0;
        for (int c = 0; c < N_CH; c++) begin hi_a[c] = 0; hi_b[c] = 0; end
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                cyc = 0;
                for (int c = 0; c < N_CH; c++) begin hi_a[c] = 0; hi_b[c] = 0; end
            end else begin
                if (fs_a) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL scoreboard_empty: frame_start with no expected entry at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        for (int c = 0; c < N_CH; c++) begin
                            chk($sformatf("high_a_ch%0d", c), hi_a[c], int'(e.wa[c]));
                            chk($sformatf("high_b_ch%0d", c), hi_b[c], int'(e.wb[c]));
                        end
                        chk("posi_a", int'(posi_a), int'(e.posi));
                        chk("posi_b", int'(posi_b), int'(e.posi));
                        chk("frame_period", cyc, PERIOD);
                        chk("frame_start_b", int'(fs_b), 1);
                    end
                    cyc = 0;
                    for (int c = 0; c < N_CH; c++) begin hi_a[c] = 0; hi_b[c] = 0; end
                end
                cyc++;
                for (int c = 0; c < N_CH; c++) begin
                    hi_a[c] += int'(pwm_a[c]);
                    hi_b[c] += int'(pwm_b[c]);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int         f;
        int         kind;
        int         r;
        logic [4:0] pos;
        model_reset();
        wait_cyc(3);
        chk("reset_pwm_a", int'(pwm_a), 0);
        chk("reset_posi_a", int'(posi_a), 0);
        chk("reset_fs_a", int'(fs_a), 0);
        release_reset();

        f = 0;
        run_frame(f++, 0, 0, 5'b00000, 4'b0000);
        run_frame(f++, 0, 0, 5'b00000, 4'b0000);
        run_frame(f++, 1, 2, 5'b01000, 4'b0000);
        run_frame(f++, 1, 0, 5'b00110, 4'b0000);
        run_frame(f++, 2, 1, 5'b00001, 4'b0000);
        run_frame(f++, 1, 1, 5'b10000, 4'b0000);
        run_frame(f++, 3, 0, 5'b00000, 4'b0001);
        while (f < 21) run_frame(f++, 0, 0, 5'b00000, 4'b0000);
        run_frame(f++, 3, 0, 5'b00000, 4'b0000);

        while (f < 50) begin
            r = $urandom_range(0, 9);
            if (r <= 4)      kind = 1;
            else if (r <= 6) kind = 2;
            else if (r == 7) kind = 3;
            else             kind = 0;
            if ($urandom_range(0, 3) != 0) pos = 5'(1 << $urandom_range(0, 4));
            else                           pos = 5'($urandom_range(0, 31));
            run_frame(f++, kind, $urandom_range(0, 5), pos, 4'($urandom_range(0, 15)));
        end

        // Asynchronous reset while every channel is mid-pulse.
        wait_cyc(50);
        chk("pre_reset_pwm_a", int'(pwm_a), 15);
        RST_N = 1'b0;
        #1;
        chk("async_reset_pwm_a", int'(pwm_a), 0);
        chk("async_reset_pwm_b", int'(pwm_b), 0);
        chk("async_reset_posi_b", int'(posi_b), 0);
        modo    = '0;
        pos_sel = '0;
        model_reset();
        wait_cyc(4);
        release_reset();
        f = 0;
        while (f < 3) run_frame(f++, 0, 0, 5'b00000, 4'b0000);
        wait_cyc(2);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
